voice_scheduler: RTL and testbench

//  Allocates queued notes to NUM_VOICES note_player voices. Buffers incoming notes in a small FIFO,

---
 rtl/voice_sched_pkg.sv | 31 +++
 rtl/note_fifo.sv | 74 +++++++
 rtl/voice_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_voice_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_sched_pkg.sv
// ---------------------------------------------------------------------------
// voice_sched_pkg
//   Shared definitions for the voice scheduler slice:
//     - sched_state_t : dispatch FSM encodings (IDLE, ISSUE)
//     - default pitch/duration widths
//     - FIFO entry width and the field offsets of a packed {pitch, dur} entry
// ---------------------------------------------------------------------------
package voice_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

    localparam int DEF_NOTE_W = 6;
    localparam int DEF_DUR_W  = 6;

    // A FIFO entry is {pitch, dur}: duration in the low bits, pitch above it.
    function automatic int entry_width(input int note_w, input int dur_w);
        return note_w + dur_w;
    endfunction

    function automatic int dur_lsb();
        return 0;
    endfunction

    function automatic int pitch_lsb(input int dur_w);
        return dur_w;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// ---------------------------------------------------------------------------
// note_fifo
//   Synchronous FIFO holding pending notes for the voice scheduler.
//   Parameters: DEPTH (power of 2, >= 2), WIDTH (entry width).
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous, active-high; empties the FIFO
//     push   in   write request (ignored while full, even with a same-cycle pop)
//     pop    in   read request (ignored while empty)
//     wdata  in   WIDTH entry to write
//     rdata  out  head entry (combinational read of the head slot)
//     full   out  count == DEPTH
//     empty  out  count == 0
//     count  out  entries held, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module note_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only slots behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// ---------------------------------------------------------------------------
// voice_scheduler
//   Buffers incoming notes and hands them out to a bank of note_player voices.
//   A note is popped in one cycle and its one-hot load pulse follows in the
//   next, so at most one dispatch happens every two cycles.
//
//   Optional feature: define VOICE_STEAL_EN to let a waiting note pre-empt the
//   least recently loaded voice when every voice is busy. Without it the note
//   waits for a voice_done and `stolen` is tied low.
//
//   Ports:
//     clk          in   system clock
//     reset        in   synchronous, active-high
//     note_valid   in   source presents a note
//     note_ready   out  FIFO has room (transfer on note_valid & note_ready)
//     note_pitch   in   pitch of the presented note (0 = rest)
//     note_dur     in   duration of the presented note
//     play_enable  in   0 holds dispatch; the FIFO still accepts
//     voice_done   in   per-voice one-cycle end-of-note pulses
//     voice_load   out  one-hot, one-cycle load pulse to the selected voice
//     voice_pitch  out  shared note bus, held between loads
//     voice_dur    out  shared note bus, held between loads
//     busy         out  registered per-voice occupied flags
//     fifo_count   out  pending notes
//     stolen       out  pulses with voice_load when a busy voice is pre-empted
// ---------------------------------------------------------------------------
module voice_scheduler
    import voice_sched_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          note_valid,
    output logic                          note_ready,
    input  logic [NOTE_W-1:0]             note_pitch,
    input  logic [DUR_W-1:0]              note_dur,
    input  logic                          play_enable,
    input  logic [NUM_VOICES-1:0]         voice_done,
    output logic [NUM_VOICES-1:0]         voice_load,
    output logic [NOTE_W-1:0]             voice_pitch,
    output logic [DUR_W-1:0]              voice_dur,
    output logic [NUM_VOICES-1:0]         busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          stolen
);

    localparam int VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ENTRY_W   = entry_width(NOTE_W, DUR_W);
    localparam int PITCH_LSB = pitch_lsb(DUR_W);
    localparam int DUR_LSB   = dur_lsb();

    sched_state_t           state;
    sched_state_t           state_next;
    logic [VIDX_W-1:0]      sel_q;
    logic [VIDX_W-1:0]      dispatch_idx;
    logic                   dispatch;
    logic [VIDX_W-1:0]      free_idx;
    logic                   free_found;
    logic [NUM_VOICES-1:0]  set_mask;
    logic [NUM_VOICES-1:0]  busy_next;
    logic [VIDX_W-1:0]      age      [NUM_VOICES];
    logic [VIDX_W-1:0]      age_next [NUM_VOICES];
    logic                   age_hit;
    logic [ENTRY_W-1:0]     fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;

`ifdef VOICE_STEAL_EN
    logic                   dispatch_steal;
    logic                   steal_q;
`endif

    note_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (note_valid),
        .pop   (dispatch),
        .wdata ({note_pitch, note_dur}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign note_ready = !fifo_full;

    // Lowest-index free voice; scanning downward lets the lowest index win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(i);
            end
        end
    end

    // Dispatch FSM: IDLE decides and pops, ISSUE drives the load pulse.
    // The pulse is suppressed while reset is asserted so a pending load is dropped.
    always_comb begin
        state_next   = state;
        dispatch     = 1'b0;
        dispatch_idx = free_idx;
        voice_load   = '0;
`ifdef VOICE_STEAL_EN
        dispatch_steal = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty && play_enable) begin
                    if (free_found) begin
                        dispatch = 1'b1;
                    end
`ifdef VOICE_STEAL_EN
                    else begin
                        dispatch       = 1'b1;
                        dispatch_idx   = age[0];
                        dispatch_steal = 1'b1;
                    end
`endif
                end
                if (dispatch) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!reset) begin
                    voice_load = NUM_VOICES'(1) << sel_q;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef VOICE_STEAL_EN
    assign stolen = (state == ISSUE) && steal_q && !reset;
`else
    assign stolen = 1'b0;
`endif

    // A dispatch sets the target's busy bit after done pulses clear theirs,
    // so a same-cycle set and done on one voice leaves it busy.
    always_comb begin
        set_mask  = dispatch ? (NUM_VOICES'(1) << dispatch_idx) : '0;
        busy_next = (busy & ~voice_done) | set_mask;
    end

    // On each load, the loaded voice is removed from its slot, everything
    // behind it moves up one place, and it rejoins at the tail (youngest).
    always_comb begin
        age_hit = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            age_next[i] = age[i];
        end
        if (state == ISSUE) begin
            for (int i = 0; i < NUM_VOICES - 1; i++) begin
                age_hit = age_hit | (age[i] == sel_q);
                if (age_hit) begin
                    age_next[i] = age[i+1];
                end
            end
            age_next[NUM_VOICES-1] = sel_q;
        end
    end

    // State, busy flags, age list and the held note bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= '0;
            sel_q       <= '0;
            voice_pitch <= '0;
            voice_dur   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                age[i] <= VIDX_W'(i);
            end
`ifdef VOICE_STEAL_EN
            steal_q     <= 1'b0;
`endif
        end else begin
            state <= state_next;
            busy  <= busy_next;
            for (int i = 0; i < NUM_VOICES; i++) begin
                age[i] <= age_next[i];
            end
            if (dispatch) begin
                sel_q       <= dispatch_idx;
                voice_pitch <= fifo_rdata[PITCH_LSB +: NOTE_W];
                voice_dur   <= fifo_rdata[DUR_LSB +: DUR_W];
`ifdef VOICE_STEAL_EN
                steal_q     <= dispatch_steal;
`endif
            end
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// ---------------------------------------------------------------------------
// tb_voice_scheduler
//   Directed bench for voice_scheduler (3 voices, 4-entry FIFO, 6-bit fields).
//   Expected load pulses are queued as notes are pushed; a negedge monitor
//   pops and compares whenever voice_load is non-zero. Honours VOICE_STEAL_EN.
// ---------------------------------------------------------------------------
module tb_voice_scheduler;

    localparam int NV = 3;
    localparam int FD = 4;
    localparam int NW = 6;
    localparam int DW = 6;

    logic          clk;
    logic          reset;
    logic          note_valid;
    logic          note_ready;
    logic [NW-1:0] note_pitch;
    logic [DW-1:0] note_dur;
    logic          play_enable;
    logic [NV-1:0] voice_done;
    logic [NV-1:0] voice_load;
    logic [NW-1:0] voice_pitch;
    logic [DW-1:0] voice_dur;
    logic [NV-1:0] busy;
    logic [2:0]    fifo_count;
    logic          stolen;

    typedef struct {
        int load;
        int pitch;
        int dur;
        int stl;
        int at;
    } exp_t;

    exp_t expq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    voice_scheduler #(
        .NUM_VOICES (NV),
        .FIFO_DEPTH (FD),
        .NOTE_W     (NW),
        .DUR_W      (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_pitch  (note_pitch),
        .note_dur    (note_dur),
        .play_enable (play_enable),
        .voice_done  (voice_done),
        .voice_load  (voice_load),
        .voice_pitch (voice_pitch),
        .voice_dur   (voice_dur),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .stolen      (stolen)
    );

    // 10-time-unit clock; cyc numbers the cycle that starts at each rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared comparison: counts every check and reports any difference.
    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectLoad(input int load, input int p, input int d, input int stl, input int at);
        exp_t e;
        e.load  = load;
        e.pitch = p;
        e.dur   = d;
        e.stl   = stl;
        e.at    = at;
        expq.push_back(e);
    endtask

    // Presents one note for one cycle.
    task automatic applyStimulus(input int p, input int d);
        note_valid = 1'b1;
        note_pitch = NW'(p);
        note_dur   = DW'(d);
        tick(1);
        note_valid = 1'b0;
    endtask

    task automatic pulseDone(input int mask);
        voice_done = NV'(mask);
        tick(1);
        voice_done = '0;
    endtask

    task automatic applyReset();
        reset       = 1'b1;
        note_valid  = 1'b0;
        voice_done  = '0;
        play_enable = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Monitor: every load pulse must match the oldest queued expectation,
    // including the cycle it was due in; stolen must never pulse on its own.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (voice_load != '0) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_load", int'(voice_load), 0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("load_mask",  int'(voice_load),  e.load);
                    checkOutput("load_pitch", int'(voice_pitch), e.pitch);
                    checkOutput("load_dur",   int'(voice_dur),   e.dur);
                    checkOutput("load_stolen", int'(stolen),     e.stl);
                    checkOutput("load_cycle", cyc,               e.at);
                end
            end else begin
                checkOutput("idle_stolen", int'(stolen), 0);
            end
        end
    end

    initial begin
        int c;
        reset       = 1'b1;
        note_valid  = 1'b0;
        note_pitch  = '0;
        note_dur    = '0;
        play_enable = 1'b1;
        voice_done  = '0;
        tick(3);

        // Reset values, observed while reset is still held.
        checkOutput("rst_load",   int'(voice_load),  0);
        checkOutput("rst_busy",   int'(busy),        0);
        checkOutput("rst_count",  int'(fifo_count),  0);
        checkOutput("rst_ready",  int'(note_ready),  1);
        checkOutput("rst_stolen", int'(stolen),      0);
        checkOutput("rst_pitch",  int'(voice_pitch), 0);
        checkOutput("rst_dur",    int'(voice_dur),   0);
        reset = 1'b0;
        tick(1);

        // Single note: pulse to voice 0 two cycles after the push.
        c = cyc;
        expectLoad(1, 12, 8, 0, c + 2);
        applyStimulus(12, 8);
        tick(1);
        checkOutput("t1_busy", int'(busy), 1);
        pulseDone(1);
        tick(1);
        checkOutput("t1_busy_cleared", int'(busy), 0);

        // Four back-to-back notes: voices 0,1,2 every other cycle, one left over.
        applyReset();
        c = cyc;
        expectLoad(1, 1, 1, 0, c + 2);
        applyStimulus(1, 1);
        expectLoad(2, 2, 2, 0, c + 4);
        applyStimulus(2, 2);
        expectLoad(4, 3, 3, 0, c + 6);
        applyStimulus(3, 3);
`ifdef VOICE_STEAL_EN
        expectLoad(1, 4, 4, 1, c + 8);
`endif
        applyStimulus(4, 4);
        tick(4);
        checkOutput("t2_busy", int'(busy), 7);
`ifdef VOICE_STEAL_EN
        checkOutput("t2_count", int'(fifo_count), 0);
`else
        checkOutput("t2_count", int'(fifo_count), 1);

        // Freeing voice 1 lets the leftover note go there.
        c = cyc;
        expectLoad(2, 4, 4, 0, c + 2);
        pulseDone(2);
        tick(2);
        checkOutput("t3_count", int'(fifo_count), 0);
        checkOutput("t3_busy",  int'(busy),       7);
`endif

        // Dispatch held: FIFO fills and refuses a fifth note.
        applyReset();
        play_enable = 1'b0;
        applyStimulus(10, 1);
        applyStimulus(11, 2);
        applyStimulus(12, 3);
        applyStimulus(13, 4);
        note_valid = 1'b1;
        note_pitch = NW'(20);
        note_dur   = DW'(5);
        #1;
        checkOutput("t4_ready_full", int'(note_ready), 0);
        checkOutput("t4_count_full", int'(fifo_count), 4);
        tick(1);
        note_valid = 1'b0;
        checkOutput("t4_count_refused", int'(fifo_count), 4);

        // Re-enabling dispatch drains in order, starting the cycle it rises.
        c = cyc;
        expectLoad(1, 10, 1, 0, c + 1);
        expectLoad(2, 11, 2, 0, c + 3);
        expectLoad(4, 12, 3, 0, c + 5);
`ifdef VOICE_STEAL_EN
        expectLoad(1, 13, 4, 1, c + 7);
`endif
        play_enable = 1'b1;
        tick(8);
`ifdef VOICE_STEAL_EN
        checkOutput("t4_count_drain", int'(fifo_count), 0);
`else
        checkOutput("t4_count_drain", int'(fifo_count), 1);
`endif
        checkOutput("t4_ready_again", int'(note_ready), 1);

        // Reset mid-operation flushes the FIFO and clears busy.
        reset = 1'b1;
        tick(1);
        checkOutput("midrst_count", int'(fifo_count), 0);
        checkOutput("midrst_busy",  int'(busy),       0);
        checkOutput("midrst_ready", int'(note_ready), 1);
        reset = 1'b0;

        // Done on voice 0 in the same cycle it is dispatched to: stays busy.
        applyReset();
        c = cyc;
        expectLoad(1, 30, 7, 0, c + 2);
        applyStimulus(30, 7);
        pulseDone(1);
        checkOutput("t5_busy_set_wins", int'(busy), 1);
        pulseDone(1);
        tick(1);
        checkOutput("t5_busy_cleared", int'(busy), 0);

        // All voices busy (loaded 0,1,2), then another note arrives.
        applyReset();
        c = cyc;
        expectLoad(1, 40, 1, 0, c + 2);
        applyStimulus(40, 1);
        expectLoad(2, 41, 2, 0, c + 4);
        applyStimulus(41, 2);
        expectLoad(4, 42, 3, 0, c + 6);
        applyStimulus(42, 3);
        tick(5);
        checkOutput("t6_all_busy", int'(busy), 7);
        c = cyc;
`ifdef VOICE_STEAL_EN
        expectLoad(1, 43, 4, 1, c + 2);
        applyStimulus(43, 4);
        tick(1);
        expectLoad(2, 44, 5, 1, c + 4);
        applyStimulus(44, 5);
        tick(3);
        checkOutput("t6_count", int'(fifo_count), 0);
        checkOutput("t6_busy",  int'(busy),       7);
`else
        applyStimulus(43, 4);
        tick(4);
        checkOutput("t6_waiting_count", int'(fifo_count), 1);
        checkOutput("t6_no_steal",      int'(stolen),     0);
        checkOutput("t6_busy",          int'(busy),       7);
        c = cyc;
        expectLoad(4, 43, 4, 0, c + 2);
        pulseDone(4);
        tick(3);
        checkOutput("t6_count_after", int'(fifo_count), 0);
`endif

        tick(5);
        checkOutput("queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
